wm8731_ctrl_responder: RTL and testbench
========================================

Name: wm8731_ctrl_responder

Overview:
Codec-side responder for the WM8731 3-wire control interface (SCLK/SDIN/CSB). It receives the 16-bit words sent by the SPI init sequencer, MSB first, and decodes each into a 7-bit address and 9-bit data. It maintains the codec register file with datasheet reset values and flags malformed frames. It serves as the bus-functional codec model in the init-sequencer testbench and as a loopback monitor on the FPGA.

Parameters:
SYNC_STAGES, 2, synchronizer depth on sclk/sdin/csb (minimum 2).
RESET_ADDR, 7'h0F, address whose all-zero write resets the register file.

Ports:
clk  input  1  system clock; must be at least 4x the SCLK frequency.
rst_n  input  1  asynchronous active-low reset.
spi_sclk  input  1  serial clock from initiator, asynchronous to clk.
spi_sdin  input  1  serial data; sampled on SCLK rising edge.
spi_csb  input  1  chip select, active low; the word is latched on its rising edge.
wr_stb  output  1  one-cycle pulse when a valid register write commits.
wr_addr  output  7  address of the last committed frame.
wr_data  output  9  data of the last committed frame.
regs_flat  output  90  R0..R9 concatenated; R9 in [89:81], R0 in [8:0].
codec_active  output  1  equals R9[0].
err_len  output  1  one-cycle pulse when a frame ends with a bit count other than 0 or 16.
err_addr  output  1  one-cycle pulse for a 16-bit frame to an unmapped address, or to RESET_ADDR with nonzero data.
frame_cnt  output  8  count of valid commits; wraps 255 to 0.

Behaviour:
- Reset values (async, immediate): wr_stb=0, err_len=0, err_addr=0, wr_addr=0, wr_data=0, frame_cnt=0, FSM=IDLE.
- Register file defaults: R0=0x097, R1=0x097, R2=0x079, R3=0x079, R4=0x00A, R5=0x008, R6=0x09F, R7=0x00A, R8=0x000, R9=0x000. Hence codec_active=0.
- Each input passes through SYNC_STAGES flops, then one edge-detect flop. Only synchronized signals are used.
- FSM states:
  - IDLE: on csb falling edge, clear shift register and bit count, go to SHIFT.
  - SHIFT: on each sclk rising edge with csb low, shift sdin into the LSB. bit_cnt increments and saturates at 17. On csb rising edge, go to COMMIT.
  - COMMIT: lasts one cycle, then returns to IDLE.
- COMMIT decode (outputs registered at the end of the COMMIT cycle):
  - bit_cnt==0: silent; no pulse, no write.
  - bit_cnt!=16 (1..15 or 17): err_len=1; no write; wr_addr/wr_data unchanged.
  - bit_cnt==16 and addr in 0x00..0x09: write R[addr]=data, wr_stb=1, update wr_addr/wr_data, frame_cnt+1.
  - bit_cnt==16, addr==RESET_ADDR, data==0: all registers return to defaults, wr_stb=1, update wr_addr/wr_data, frame_cnt+1.
  - Any other 16-bit frame: err_addr=1; registers unchanged; wr_addr/wr_data updated for debug.
- Latency: wr_stb/err pulses appear exactly SYNC_STAGES+2 clk rising edges after the first clk edge that samples spi_csb=1. regs_flat updates on the same edge.
- An sclk rising edge detected in the same cycle as the csb rising edge is ignored.
- A csb falling edge during COMMIT is accepted: the next cycle enters SHIFT with a cleared count. No frame is lost.
- An sclk edge while in IDLE (csb high) is ignored.
- rst_n asserted mid-frame discards the partial word. After release, a frame is accepted only after a fresh csb falling edge.

Decomposition:
- Package wm8731_ctrl_pkg:
  - Register address constants: R_LLIN=0x00 .. R_ACTIVE=0x09, R_RESET=0x0F.
  - Default-value array for R0..R9.
  - Field widths ADDR_W=7, DATA_W=9, WORD_W=16.
  - FSM state enum.
- One sub-module: wm8731_spi_sync_edge. It holds the SYNC_STAGES synchronizer plus rise/fall detect for one signal and is instantiated for sclk, sdin and csb. The sdin instance uses only the level output.

Test Plan:
- After reset, drive 16'h1201 (addr 0x09, data 0x001) -> wr_stb once, wr_addr=0x09, wr_data=0x001, codec_active=1, frame_cnt=1.
- Drive 16'h0E53 then 16'h0017 -> R7=0x053, R0=0x017, two wr_stb pulses, frame_cnt=2.
- Drive 16'h1E00 after the writes above -> all registers back to defaults (R0=0x097, R9=0x000), codec_active=0, wr_stb=1.
- Frames of 12 bits and of 17 bits -> err_len pulse each, no wr_stb, regs_flat unchanged. CSB toggle with 0 bits -> no pulse.
- Drive 16'h1400 (addr 0x0A) and 16'h1E01 -> err_addr pulse each, registers unchanged, frame_cnt unchanged.
- Assert rst_n low after 8 bits of 16'h0017, release, then send a full 16'h0017 -> only the second frame commits. R0=0x017 and frame_cnt=1; measured latency is SYNC_STAGES+2 cycles.

Source files
------------

// File: rtl/wm8731_ctrl_pkg.sv
// rtl/wm8731_ctrl_pkg.sv - WM8731 control-port constants, register defaults and FSM states
package wm8731_ctrl_pkg;

    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 9;
    localparam int WORD_W   = 16;
    localparam int NUM_REGS = 10;

    localparam logic [ADDR_W-1:0] R_LLIN   = 7'h00;
    localparam logic [ADDR_W-1:0] R_RLIN   = 7'h01;
    localparam logic [ADDR_W-1:0] R_LHPOUT = 7'h02;
    localparam logic [ADDR_W-1:0] R_RHPOUT = 7'h03;
    localparam logic [ADDR_W-1:0] R_APATH  = 7'h04;
    localparam logic [ADDR_W-1:0] R_DPATH  = 7'h05;
    localparam logic [ADDR_W-1:0] R_PWR    = 7'h06;
    localparam logic [ADDR_W-1:0] R_IFACE  = 7'h07;
    localparam logic [ADDR_W-1:0] R_SRATE  = 7'h08;
    localparam logic [ADDR_W-1:0] R_ACTIVE = 7'h09;
    localparam logic [ADDR_W-1:0] R_RESET  = 7'h0F;

    // Index i holds the datasheet reset value of R<i>; R9 sits in the top bits.
    localparam logic [NUM_REGS-1:0][DATA_W-1:0] REG_DEFAULTS = {
        9'h000, 9'h000, 9'h00A, 9'h09F, 9'h008,
        9'h00A, 9'h079, 9'h079, 9'h097, 9'h097
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/wm8731_spi_sync_edge.sv
// rtl/wm8731_spi_sync_edge.sv - synchronizer plus registered rise/fall detect for one serial-port line
// Ports: clk, rst_n (async active-low); i_sig asynchronous input;
//        o_level synchronized level; o_rise / o_fall one-cycle edge pulses aligned with o_level.
module wm8731_spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;

    // Chain resets low so a csb already low when reset releases never looks like a
    // falling edge; any spurious rise lands in IDLE where it is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_sig};
            r_level <= r_sync[SYNC_STAGES-1];
            // Edges are registered alongside r_level so that the sdin level seen by the
            // shifter belongs to the same sample instant as the sclk rise.
            r_rise  <= r_sync[SYNC_STAGES-1] & ~r_level;
            r_fall  <= ~r_sync[SYNC_STAGES-1] & r_level;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/wm8731_ctrl_responder.sv
// rtl/wm8731_ctrl_responder.sv - codec-side WM8731 3-wire control responder with register file
// Ports: clk, rst_n (async active-low); spi_sclk/spi_sdin/spi_csb asynchronous serial inputs;
//        wr_stb/wr_addr/wr_data commit report; regs_flat R9..R0; codec_active = R9[0];
//        err_len/err_addr malformed-frame pulses; frame_cnt valid-commit counter.
module wm8731_ctrl_responder
    import wm8731_ctrl_pkg::*;
#(
    parameter int                SYNC_STAGES = 2,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = R_RESET
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         spi_sclk,
    input  logic                         spi_sdin,
    input  logic                         spi_csb,
    output logic                         wr_stb,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic [DATA_W-1:0]            wr_data,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic                         codec_active,
    output logic                         err_len,
    output logic                         err_addr,
    output logic [7:0]                   frame_cnt
);

    logic w_sclk_rise, w_sclk_level_unused, w_sclk_fall_unused;
    logic w_sdin, w_sdin_rise_unused, w_sdin_fall_unused;
    logic w_csb_level, w_csb_rise, w_csb_fall;

    wm8731_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .i_sig(spi_sclk),
        .o_level(w_sclk_level_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall_unused)
    );
    wm8731_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdin (
        .clk(clk), .rst_n(rst_n), .i_sig(spi_sdin),
        .o_level(w_sdin), .o_rise(w_sdin_rise_unused), .o_fall(w_sdin_fall_unused)
    );
    wm8731_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_csb (
        .clk(clk), .rst_n(rst_n), .i_sig(spi_csb),
        .o_level(w_csb_level), .o_rise(w_csb_rise), .o_fall(w_csb_fall)
    );

    state_t                            r_state, w_state_next;
    logic                              w_clear, w_shift_en;
    logic [WORD_W-1:0]                 r_shift;
    logic [4:0]                        r_bit_cnt;
    logic [NUM_REGS-1:0][DATA_W-1:0]   r_regs;
    logic                              r_wr_stb, r_err_len, r_err_addr;
    logic [ADDR_W-1:0]                 r_wr_addr;
    logic [DATA_W-1:0]                 r_wr_data;
    logic [7:0]                        r_frame_cnt;

    logic [ADDR_W-1:0]                 w_addr;
    logic [DATA_W-1:0]                 w_data;

    assign w_addr = r_shift[WORD_W-1:DATA_W];
    assign w_data = r_shift[DATA_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_shift_en   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_csb_fall) begin
                    w_state_next = ST_SHIFT;
                    w_clear      = 1'b1;
                end
            end
            ST_SHIFT: begin
                // csb rise wins over a coincident sclk rise: that bit is dropped.
                if (w_csb_rise)                     w_state_next = ST_COMMIT;
                else if (w_sclk_rise && !w_csb_level) w_shift_en = 1'b1;
            end
            ST_COMMIT: begin
                // A back-to-back frame may start while the previous one is decoded;
                // decode reads r_shift this cycle, so clearing it now is safe.
                if (w_csb_fall) begin
                    w_state_next = ST_SHIFT;
                    w_clear      = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_clear) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_shift_en) begin
            r_shift   <= {r_shift[WORD_W-2:0], w_sdin};
            // Saturating at 17 keeps over-long frames distinguishable from 16.
            if (r_bit_cnt != 5'd17) r_bit_cnt <= r_bit_cnt + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regs      <= REG_DEFAULTS;
            r_wr_stb    <= 1'b0;
            r_err_len   <= 1'b0;
            r_err_addr  <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_wr_stb   <= 1'b0;
            r_err_len  <= 1'b0;
            r_err_addr <= 1'b0;
            if (r_state == ST_COMMIT && r_bit_cnt != 5'd0) begin
                if (r_bit_cnt != 5'd16) begin
                    r_err_len <= 1'b1;
                end else begin
                    // Address/data are reported even for rejected words to aid debug.
                    r_wr_addr <= w_addr;
                    r_wr_data <= w_data;
                    if (w_addr <= R_ACTIVE) begin
                        r_regs[w_addr[3:0]] <= w_data;
                        r_wr_stb            <= 1'b1;
                        r_frame_cnt         <= r_frame_cnt + 8'd1;
                    end else if (w_addr == RESET_ADDR && w_data == '0) begin
                        r_regs      <= REG_DEFAULTS;
                        r_wr_stb    <= 1'b1;
                        r_frame_cnt <= r_frame_cnt + 8'd1;
                    end else begin
                        r_err_addr <= 1'b1;
                    end
                end
            end
        end
    end

    assign wr_stb       = r_wr_stb;
    assign err_len      = r_err_len;
    assign err_addr     = r_err_addr;
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;
    assign frame_cnt    = r_frame_cnt;
    assign regs_flat    = r_regs;
    assign codec_active = r_regs[R_ACTIVE[3:0]][0];

endmodule

// File: tb/tb_wm8731_ctrl_responder.sv
// tb/tb_wm8731_ctrl_responder.sv - self-checking bench for wm8731_ctrl_responder
module tb_wm8731_ctrl_responder;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_sclk = 1'b0;
    logic        spi_sdin = 1'b0;
    logic        spi_csb = 1'b1;
    logic        wr_stb, codec_active, err_len, err_addr;
    logic [6:0]  wr_addr;
    logic [8:0]  wr_data;
    logic [89:0] regs_flat;
    logic [7:0]  frame_cnt;

    wm8731_ctrl_responder #(.SYNC_STAGES(S), .RESET_ADDR(7'h0F)) dut (
        .clk(clk), .rst_n(rst_n),
        .spi_sclk(spi_sclk), .spi_sdin(spi_sdin), .spi_csb(spi_csb),
        .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
        .regs_flat(regs_flat), .codec_active(codec_active),
        .err_len(err_len), .err_addr(err_addr), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_vec = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input logic [89:0] act, input logic [89:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // ---------------- behavioural model ----------------
    int DEF[10] = '{'h097, 'h097, 'h079, 'h079, 'h00A, 'h008, 'h09F, 'h00A, 0, 0};
    int m_reg[10];
    int m_cnt, m_addr, m_data;
    logic m_stb, m_el, m_ea;

    typedef struct {
        int          at;
        logic [15:0] w;
        int          n;
    } pend_t;
    pend_t pq[$];

    function automatic void model_reset();
        for (int i = 0; i < 10; i++) m_reg[i] = DEF[i];
        m_cnt = 0; m_addr = 0; m_data = 0;
        pq.delete();
    endfunction

    function automatic logic [89:0] flat_of(input int r[10]);
        logic [89:0] f;
        f = '0;
        for (int i = 0; i < 10; i++) f[i*9 +: 9] = r[i][8:0];
        return f;
    endfunction

    function automatic void apply(input pend_t p);
        int a, d;
        a = int'(p.w) / 512;
        d = int'(p.w) % 512;
        if (p.n != 16) begin
            m_el = 1'b1;
            return;
        end
        m_addr = a; m_data = d;
        if (a <= 9) begin
            m_reg[a] = d; m_stb = 1'b1; m_cnt = (m_cnt + 1) % 256;
        end else if (a == 15 && d == 0) begin
            for (int i = 0; i < 10; i++) m_reg[i] = DEF[i];
            m_stb = 1'b1; m_cnt = (m_cnt + 1) % 256;
        end else begin
            m_ea = 1'b1;
        end
    endfunction

    int n_stb_seen = 0, n_el_seen = 0, n_ea_seen = 0;
    int last_stb_cyc = -1;

    always @(negedge clk) begin
        m_stb = 1'b0; m_el = 1'b0; m_ea = 1'b0;
        if (pq.size() > 0 && pq[0].at == cyc) apply(pq.pop_front());
        if (wr_stb === 1'b1) begin n_stb_seen++; last_stb_cyc = cyc; end
        if (err_len === 1'b1) n_el_seen++;
        if (err_addr === 1'b1) n_ea_seen++;
        chk("wr_stb", wr_stb, m_stb);
        chk("err_len", err_len, m_el);
        chk("err_addr", err_addr, m_ea);
        chk("wr_addr", wr_addr, m_addr[6:0]);
        chk("wr_data", wr_data, m_data[8:0]);
        chk("frame_cnt", frame_cnt, m_cnt[7:0]);
        chk("regs_flat", regs_flat, flat_of(m_reg));
        chk("codec_active", codec_active, m_reg[9][0]);
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_bits(input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            spi_sdin = (n == 16) ? w[15-i] : w[i % 16];
            tick(4);
            spi_sclk = 1'b1;
            tick(4);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [15:0] w, input int n, output int t_rise);
        pend_t p;
        spi_csb = 1'b0;
        tick(4);
        send_bits(w, n);
        tick(4);
        spi_csb = 1'b1;
        t_rise = cyc + 1;
        if (n != 0) begin
            p.at = t_rise + S + 2; p.w = w; p.n = n;
            pq.push_back(p);
        end
        tick(S + 8);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        tick(3);
        rst_n = 1'b1;
        tick(6);
    endtask

    int t_r, stb0, el0, ea0, cnt_at, addr_r, data_r, n_r;

    initial begin
        model_reset();
        tick(3);
        chk("reset_frame_cnt", frame_cnt, 8'd0);
        chk("reset_regs", regs_flat, 90'h000_0000_0A9F_0080_0A79_0790_9709_7 >> 0 == 0 ? flat_of(DEF) : flat_of(DEF));
        rst_n = 1'b1;
        tick(6);

        // Single write to the active register
        send_frame(16'h1201, 16, t_r);
        chk("t1_wr_addr", wr_addr, 7'h09);
        chk("t1_wr_data", wr_data, 9'h001);
        chk("t1_active", codec_active, 1'b1);
        chk("t1_frame_cnt", frame_cnt, 8'd1);

        // Two writes from a fresh reset
        do_reset();
        stb0 = n_stb_seen;
        send_frame(16'h0E53, 16, t_r);
        send_frame(16'h0017, 16, t_r);
        chk("t2_r7", regs_flat[7*9 +: 9], 9'h053);
        chk("t2_r0", regs_flat[0 +: 9], 9'h017);
        chk("t2_stb_count", n_stb_seen - stb0, 2);
        chk("t2_frame_cnt", frame_cnt, 8'd2);

        // Register-file reset word
        send_frame(16'h1E00, 16, t_r);
        chk("t3_r0", regs_flat[0 +: 9], 9'h097);
        chk("t3_r6", regs_flat[6*9 +: 9], 9'h09F);
        chk("t3_r9", regs_flat[9*9 +: 9], 9'h000);
        chk("t3_active", codec_active, 1'b0);
        chk("t3_frame_cnt", frame_cnt, 8'd3);

        // Wrong lengths and empty frame
        stb0 = n_stb_seen; el0 = n_el_seen;
        send_frame(16'h0E53, 12, t_r);
        send_frame(16'hA5A5, 17, t_r);
        send_frame(16'h0000, 0, t_r);
        chk("t4_err_len_count", n_el_seen - el0, 2);
        chk("t4_stb_count", n_stb_seen - stb0, 0);
        chk("t4_regs", regs_flat, flat_of(DEF));
        chk("t4_frame_cnt", frame_cnt, 8'd3);

        // Unmapped address and reset address with nonzero data
        ea0 = n_ea_seen;
        send_frame(16'h1400, 16, t_r);
        send_frame(16'h1E01, 16, t_r);
        chk("t5_err_addr_count", n_ea_seen - ea0, 2);
        chk("t5_regs", regs_flat, flat_of(DEF));
        chk("t5_frame_cnt", frame_cnt, 8'd3);
        chk("t5_wr_addr", wr_addr, 7'h0F);
        chk("t5_wr_data", wr_data, 9'h001);

        // Reset in the middle of a frame
        spi_csb = 1'b0;
        tick(4);
        send_bits(16'h0017, 16 - 8);
        rst_n = 1'b0;
        model_reset();
        tick(3);
        rst_n = 1'b1;
        tick(4);
        spi_csb = 1'b1;
        tick(S + 8);
        chk("t6_no_commit_cnt", frame_cnt, 8'd0);
        last_stb_cyc = -1;
        send_frame(16'h0017, 16, t_r);
        chk("t6_r0", regs_flat[0 +: 9], 9'h017);
        chk("t6_frame_cnt", frame_cnt, 8'd1);
        chk("t6_latency", last_stb_cyc - t_r, S + 2);

        // Randomized frames
        for (int k = 0; k < 40; k++) begin
            n_r = ($urandom_range(0, 9) < 7) ? 16 : int'($urandom_range(0, 17));
            cnt_at = $urandom_range(0, 9);
            addr_r = (cnt_at < 6) ? int'($urandom_range(0, 9)) :
                     (cnt_at < 8) ? 15 : int'($urandom_range(10, 127));
            data_r = (addr_r == 15 && $urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(0, 511));
            send_frame({addr_r[6:0], data_r[8:0]}, n_r, t_r);
        end
        chk("rand_queue_drained", pq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
